seven_segment_scanner: RTL and testbench

SEVEN_SEGMENT_SCANNER -- requirements
Module: SevenSegmentScanner

---
 rtl/seven_segment_scanner_if.sv | 24 ++
 rtl/seven_segment_scanner.sv | 99 +++++++++
 tb/tb_seven_segment_scanner.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_if.sv
// Display-side bundle for the scanner: packed BCD in, multiplexed LED drive out.
// master = whoever supplies the time value; slave = the scanner itself.
interface seven_segment_scanner_if #(
  parameter int NUMBER_OF_DIGITS         = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT = 4
);
  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number;
  logic                                                 hold;
  logic                                                 blank_leading_zero;
  logic                                                 colon_enable;
  logic [6:0]                                           segments;
  logic                                                 dp;
  logic [NUMBER_OF_DIGITS-1:0]                          digit_select;

  modport master (
    output number, hold, blank_leading_zero, colon_enable,
    input  segments, dp, digit_select
  );

  modport slave (
    input  number, hold, blank_leading_zero, colon_enable,
    output segments, dp, digit_select
  );
endinterface

// File: rtl/seven_segment_scanner.sv
// Purpose: time-multiplexed MM.SS seven-segment driver with frame-aligned snapshot and anti-ghost blanking.
// Latency: every output is registered, one clk after the prescaler/scan state that selects it.
// Backpressure: none; free-running scan, inputs sampled every cycle, snapshot refreshed only at frame wrap.
module seven_segment_scanner #(
  parameter int NUMBER_OF_DIGITS         = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT = 4,
  parameter int REFRESH_DIVIDE           = 100_000,
  parameter int BLANK_CYCLES             = 1_000
) (
  input  logic                  clk,
  input  logic                  rst,
  seven_segment_scanner_if.slave disp
);

  localparam int CNT_W       = (REFRESH_DIVIDE > 2) ? $clog2(REFRESH_DIVIDE) : 1;
  localparam int IDX_W       = (NUMBER_OF_DIGITS > 2) ? $clog2(NUMBER_OF_DIGITS) : 1;
  localparam int NUM_W       = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
  localparam int COLON_DIGIT = 2;

  logic [CNT_W-1:0]                    prescaler;
  logic [IDX_W-1:0]                    scan_idx;
  logic [NUM_W-1:0]                    snapshot;
  logic                                tick;
  logic                                frame_wrap;
  logic [NUMBER_OF_BITS_PER_DIGIT-1:0] cur_digit;
  logic [6:0]                          seg_nxt;
  logic                                dp_nxt;
  logic [NUMBER_OF_DIGITS-1:0]         sel_nxt;

  // Active-high gfedcba pattern; non-decimal codes show a dash.
  function automatic logic [6:0] decode(input logic [NUMBER_OF_BITS_PER_DIGIT-1:0] v);
    logic [6:0] pat;
    case (32'(v))
      0:       pat = 7'h3F;
      1:       pat = 7'h06;
      2:       pat = 7'h5B;
      3:       pat = 7'h4F;
      4:       pat = 7'h66;
      5:       pat = 7'h6D;
      6:       pat = 7'h7D;
      7:       pat = 7'h07;
      8:       pat = 7'h7F;
      9:       pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  assign tick       = (prescaler == CNT_W'(REFRESH_DIVIDE - 1));
  assign frame_wrap = tick && (scan_idx == IDX_W'(NUMBER_OF_DIGITS - 1));
  assign cur_digit  = snapshot[scan_idx*NUMBER_OF_BITS_PER_DIGIT +: NUMBER_OF_BITS_PER_DIGIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler <= '0;
      scan_idx  <= '0;
      snapshot  <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + CNT_W'(1);
      if (tick) begin
        scan_idx <= frame_wrap ? '0 : scan_idx + IDX_W'(1);
      end
      // Loading only at the last-digit wrap keeps a whole frame coherent (no tearing).
      if (frame_wrap && !disp.hold) begin
        snapshot <= disp.number;
      end
    end
  end

  always_comb begin
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    sel_nxt = '1;
    if (prescaler >= CNT_W'(BLANK_CYCLES)) begin
      sel_nxt[scan_idx] = 1'b0;
      seg_nxt           = ~decode(cur_digit);
      if (disp.blank_leading_zero && (scan_idx == IDX_W'(NUMBER_OF_DIGITS - 1)) &&
          (cur_digit == '0)) begin
        seg_nxt = 7'h7F;
      end
      if (disp.colon_enable && (scan_idx == IDX_W'(COLON_DIGIT))) begin
        dp_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp.segments     <= 7'h7F;
      disp.dp           <= 1'b1;
      disp.digit_select <= '1;
    end else begin
      disp.segments     <= seg_nxt;
      disp.dp           <= dp_nxt;
      disp.digit_select <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized bench for seven_segment_scanner: cycle-count reference model plus literal anchors.
module tb_seven_segment_scanner;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int ND = 4;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_segment_scanner_if #(.NUMBER_OF_DIGITS(ND), .NUMBER_OF_BITS_PER_DIGIT(BD)) disp();

  seven_segment_scanner #(
    .NUMBER_OF_DIGITS(ND), .NUMBER_OF_BITS_PER_DIGIT(BD),
    .REFRESH_DIVIDE(RD), .BLANK_CYCLES(BC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .disp(disp)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] font [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Model state: cycles elapsed since reset and the frozen display value.
  int          n;
  logic [15:0] snap;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_sel;
  bit          model_ok = 0;

  always @(posedge clk) begin
    int         pre, idx;
    logic [3:0] d;
    logic [6:0] pat;
    if (rst) begin
      n = 0; snap = 16'h0; exp_seg = 7'h7F; exp_dp = 1'b1; exp_sel = 4'hF; model_ok = 1;
    end else if (model_ok) begin
      pre = n % RD;
      idx = (n / RD) % ND;
      d   = 4'((snap >> (4 * idx)) & 16'hF);
      if (pre < BC) begin
        exp_sel = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        exp_sel = 4'hF & ~(4'b1 << idx);
        pat = (d < 10) ? font[int'(d)] : 7'h40;
        if (disp.blank_leading_zero && idx == ND - 1 && d == 0) pat = 7'h00;
        exp_seg = ~pat;
        exp_dp  = !(disp.colon_enable && idx == 2);
      end
      if (n % (RD * ND) == RD * ND - 1 && !disp.hold) snap = disp.number;
      n++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      vectors++;
      if ({disp.digit_select, disp.segments, disp.dp} !== {exp_sel, exp_seg, exp_dp}) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t got sel=%h seg=%h dp=%b want sel=%h seg=%h dp=%b",
                 $time, disp.digit_select, disp.segments, disp.dp, exp_sel, exp_seg, exp_dp);
      end
      vectors++;
      if ($countones(~disp.digit_select) > 1) begin
        miscompares++;
        $display("FAIL one_hot t=%0t got sel=%b want at most one zero", $time, disp.digit_select);
      end
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [3:0] sel, input logic [6:0] seg, input logic dp);
    vectors++;
    if ({disp.digit_select, disp.segments, disp.dp} !== {sel, seg, dp}) begin
      miscompares++;
      $display("FAIL %s got sel=%h seg=%h dp=%b want sel=%h seg=%h dp=%b",
               name, disp.digit_select, disp.segments, disp.dp, sel, seg, dp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    lit("reset_off", 4'hF, 7'h7F, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    disp.number = 16'h1234; disp.hold = 1'b0;
    disp.blank_leading_zero = 1'b0; disp.colon_enable = 1'b0;
    cyc(1);

    // Basic 1234 scan; first new-value digit appears 35 edges after reset.
    do_reset();
    cyc(35); lit("d0_4", 4'hE, 7'h19, 1'b1);
    cyc(8);  lit("d1_3", 4'hD, 7'h30, 1'b1);
    cyc(8);  lit("d2_2", 4'hB, 7'h24, 1'b1);
    cyc(8);  lit("d3_1", 4'h7, 7'h79, 1'b1);
    cyc(6);  lit("blank_win", 4'hF, 7'h7F, 1'b1);

    // Leading-zero blank and colon.
    disp.number = 16'h0507; disp.blank_leading_zero = 1'b1; disp.colon_enable = 1'b1;
    do_reset();
    cyc(35); lit("d0_7", 4'hE, 7'h78, 1'b1);
    cyc(16); lit("d2_5_colon", 4'hB, 7'h12, 1'b0);
    cyc(8);  lit("d3_lzb", 4'h7, 7'h7F, 1'b1);

    // Hold freezes 0102; release mid-frame only takes effect at next frame.
    disp.number = 16'h0102; disp.blank_leading_zero = 1'b0; disp.colon_enable = 1'b0;
    do_reset();
    cyc(35);
    disp.hold = 1'b1; disp.number = 16'h0959;
    cyc(64); lit("hold_d0", 4'hE, 7'h24, 1'b1);
    cyc(8);  lit("hold_d1", 4'hD, 7'h40, 1'b1);
    disp.hold = 1'b0;
    cyc(8);  lit("rel_mid_d2", 4'hB, 7'h79, 1'b1);
    cyc(8);  lit("rel_mid_d3", 4'h7, 7'h40, 1'b1);
    cyc(8);  lit("rel_new_d0", 4'hE, 7'h10, 1'b1);

    // Non-decimal digits show a dash.
    disp.number = 16'h00AF;
    do_reset();
    cyc(35); lit("dash_d0", 4'hE, 7'h3F, 1'b1);
    cyc(8);  lit("dash_d1", 4'hD, 7'h3F, 1'b1);
    cyc(8);  lit("zero_d2", 4'hB, 7'h40, 1'b1);
    cyc(8);  lit("zero_d3", 4'h7, 7'h40, 1'b1);
    disp.blank_leading_zero = 1'b1;
    cyc(32); lit("lzb_d3", 4'h7, 7'h7F, 1'b1);

    // Reset mid-frame at prescaler 5, scan index 2.
    disp.blank_leading_zero = 1'b0; disp.hold = 1'b1;
    do_reset();
    cyc(21);
    do_reset();
    disp.hold = 1'b0;
    cyc(1); lit("rst_blank0", 4'hF, 7'h7F, 1'b1);
    cyc(1); lit("rst_blank1", 4'hF, 7'h7F, 1'b1);
    cyc(1); lit("rst_d0_zero", 4'hE, 7'h40, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) disp.number = 16'($urandom);
      if ($urandom_range(0, 39) == 0) disp.hold = ~disp.hold;
      if ($urandom_range(0, 49) == 0) disp.blank_leading_zero = ~disp.blank_leading_zero;
      if ($urandom_range(0, 49) == 0) disp.colon_enable = ~disp.colon_enable;
      if ($urandom_range(0, 19) == 0) disp.number[15:12] = 4'h0;
      rst = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
